// File: rtl/sad_search_ctrl_pkg.sv
// Shared types and constants for the SAD candidate search controller.
package sad_search_ctrl_pkg;

    localparam int WIDTH_DEF   = 8;
    localparam int N_BEATS_DEF = 16;
    localparam int N_CAND_DEF  = 8;

    // One clear cycle, the read burst, one drain cycle and one compare cycle.
    localparam int CAND_CYCLES = N_BEATS_DEF + 3;

    function automatic int sad_width(input int pix_w);
        return pix_w + 6;
    endfunction

    localparam int SAD_W_DEF = sad_width(WIDTH_DEF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_READ,
        ST_DRAIN,
        ST_COMPARE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sad_best_tracker.sv
// Running-minimum register for the SAD search: keeps the smallest SAD and its candidate index.
module sad_best_tracker #(
    parameter int SAD_W  = 14,
    parameter int CIDX_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_first,
    input  logic              cmp_en,
    input  logic [SAD_W-1:0]  sad_in,
    input  logic [CIDX_W-1:0] cand,
    output logic [SAD_W-1:0]  best_sad,
    output logic [CIDX_W-1:0] best_idx
);

    logic take;

    // Strict less-than keeps the lower index on ties.
    assign take = cmp_en && (load_first || (sad_in < best_sad));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_sad <= '0;
            best_idx <= '0;
        end else if (take) begin
            best_sad <= sad_in;
            best_idx <= cand;
        end
    end

endmodule

// File: rtl/sad_search_ctrl.sv
// Sequences one SAD datapath over N_CAND candidate blocks and reports the best match.
//   state   | meaning
//   IDLE    | waiting for start
//   CLEAR   | clear accumulator, beat = 0
//   READ    | issue N_BEATS reads for the current candidate
//   DRAIN   | last beat accumulates
//   COMPARE | sad_in complete, update best, pick next candidate
//   DONE    | result valid until ack
module sad_search_ctrl
    import sad_search_ctrl_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int N_BEATS = N_BEATS_DEF,
    parameter int N_CAND  = N_CAND_DEF,
    parameter int BEAT_W  = 4,
    parameter int CIDX_W  = 3,
    parameter int SAD_W   = sad_width(WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     ack,
    input  logic                     abort,
    output logic [BEAT_W-1:0]        ori_addr,
    output logic [CIDX_W+BEAT_W-1:0] can_addr,
    output logic                     mem_rd,
    output logic                     sad_clr,
    output logic                     sad_en,
    input  logic [SAD_W-1:0]         sad_in,
    output logic                     busy,
    output logic                     done,
    output logic [SAD_W-1:0]         best_sad,
    output logic [CIDX_W-1:0]        best_idx
);

    state_t              state;
    state_t              state_nxt;
    logic [BEAT_W-1:0]   beat;
    logic [CIDX_W-1:0]   cand;
    logic                sad_en_q;
    logic                last_beat;
    logic                last_cand;
    logic                kill;

    assign last_beat = (beat == BEAT_W'(N_BEATS - 1));
    assign last_cand = (cand == CIDX_W'(N_CAND - 1));
    assign kill      = abort && (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (start && !abort) state_nxt = ST_CLEAR;
                ST_CLEAR:   state_nxt = ST_READ;
                ST_READ:    if (last_beat) state_nxt = ST_DRAIN;
                ST_DRAIN:   state_nxt = ST_COMPARE;
                ST_COMPARE: state_nxt = last_cand ? ST_DONE : ST_CLEAR;
                ST_DONE:    if (ack) state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_rd  = 1'b0;
        sad_clr = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state)
            ST_IDLE:  busy    = 1'b0;
            ST_CLEAR: sad_clr = 1'b1;
            ST_READ:  mem_rd  = 1'b1;
            ST_DONE:  done    = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat <= '0;
            cand <= '0;
        end else if (kill) begin
            beat <= '0;
            cand <= '0;
        end else begin
            case (state)
                ST_IDLE:    if (start) cand <= '0;
                ST_CLEAR:   beat <= '0;
                ST_READ:    beat <= beat + BEAT_W'(1);
                ST_COMPARE: if (!last_cand) cand <= cand + CIDX_W'(1);
                default:    ;
            endcase
        end
    end

    // Memory data lands one cycle after the read strobe, so accumulation trails it by one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sad_en_q <= 1'b0;
        end else begin
            sad_en_q <= mem_rd && !abort;
        end
    end

    assign sad_en   = sad_en_q;
    assign ori_addr = beat;
    assign can_addr = {cand, beat};

    // An abort landing on COMPARE must not leave a partial result behind.
    sad_best_tracker #(
        .SAD_W  (SAD_W),
        .CIDX_W (CIDX_W)
    ) u_best (
        .clk        (clk),
        .rst        (rst),
        .load_first (cand == '0),
        .cmp_en     ((state == ST_COMPARE) && !abort),
        .sad_in     (sad_in),
        .cand       (cand),
        .best_sad   (best_sad),
        .best_idx   (best_idx)
    );

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Directed bench for sad_search_ctrl with a behavioural SAD datapath and block memory.
module tb_sad_search_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        ack;
    logic        abort;
    logic [3:0]  ori_addr;
    logic [6:0]  can_addr;
    logic        mem_rd;
    logic        sad_clr;
    logic        sad_en;
    logic [13:0] sad_in;
    logic        busy;
    logic        done;
    logic [13:0] best_sad;
    logic [2:0]  best_idx;

    int checks;
    int failures;

    logic [13:0] sad_tab [8];
    logic [13:0] dq;
    logic [13:0] acc;

    int          lat;
    bit          timed_out;
    logic [13:0] best_mid;
    int          rd2_cnt;
    int          en2_cnt;
    int          clr2_cnt;
    bit          addr2_ok;
    bit          lag_ok;
    bit          clr_order_ok;

    sad_search_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ack      (ack),
        .abort    (abort),
        .ori_addr (ori_addr),
        .can_addr (can_addr),
        .mem_rd   (mem_rd),
        .sad_clr  (sad_clr),
        .sad_en   (sad_en),
        .sad_in   (sad_in),
        .busy     (busy),
        .done     (done),
        .best_sad (best_sad),
        .best_idx (best_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each candidate's SAD is spread over 16 beats; beat 0 carries the remainder.
    function automatic logic [13:0] beat_val(input logic [2:0] c, input logic [3:0] b);
        int s;
        s = int'(sad_tab[c]);
        if (b == 4'd0) return 14'(s - 15 * (s / 16));
        return 14'(s / 16);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dq  <= '0;
            acc <= '0;
        end else begin
            if (mem_rd) dq <= beat_val(can_addr[6:4], can_addr[3:0]);
            if (sad_clr) acc <= '0;
            else if (sad_en) acc <= acc + dq;
        end
    end
    assign sad_in = acc;

    task automatic load_tab(input int s0, s1, s2, s3, s4, s5, s6, s7);
        sad_tab[0] = 14'(s0); sad_tab[1] = 14'(s1); sad_tab[2] = 14'(s2); sad_tab[3] = 14'(s3);
        sad_tab[4] = 14'(s4); sad_tab[5] = 14'(s5); sad_tab[6] = 14'(s6); sad_tab[7] = 14'(s7);
    endtask

    task automatic run_search(input bit mid_start);
        int   cyc;
        logic prev_rd;
        rd2_cnt = 0; en2_cnt = 0; clr2_cnt = 0;
        addr2_ok = 1; lag_ok = 1; clr_order_ok = 1; best_mid = '0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        prev_rd = 1'b0;
        while (1) begin
            if (sad_en !== prev_rd) lag_ok = 0;
            prev_rd = mem_rd;
            if (cyc == 19) best_mid = best_sad;
            if (mid_start) start = (cyc == 50);
            if (can_addr[6:4] == 3'd2) begin
                if (sad_clr) begin
                    clr2_cnt++;
                    if (rd2_cnt != 0) clr_order_ok = 0;
                end
                if (mem_rd) begin
                    if (int'(can_addr) != 32'h20 + rd2_cnt) addr2_ok = 0;
                    rd2_cnt++;
                end
                if (sad_en) en2_cnt++;
            end
            if (done === 1'b1 || cyc >= 400) break;
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        lat = cyc;
        timed_out = (done !== 1'b1);
    endtask

    task automatic finish_ack();
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; ack = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (mem_rd !== 1'b0 || sad_en !== 1'b0 || sad_clr !== 1'b0) begin
            failures++; $display("FAIL reset_strobes got=%0b%0b%0b exp=000", mem_rd, sad_en, sad_clr); end
        checks++; if (ori_addr !== 4'd0 || can_addr !== 7'd0) begin
            failures++; $display("FAIL reset_addr got=%0h/%0h exp=0/0", ori_addr, can_addr); end
        checks++; if (best_sad !== 14'd0 || best_idx !== 3'd0) begin
            failures++; $display("FAIL reset_best got=%0d/%0d exp=0/0", best_sad, best_idx); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_min_mid();
        load_tab(500, 400, 300, 200, 100, 600, 700, 800);
        run_search(1'b1);
        checks++; if (timed_out) begin failures++; $display("FAIL mid_timeout got=no_done exp=done"); end
        checks++; if (lat != 152) begin failures++; $display("FAIL mid_latency got=%0d exp=152", lat); end
        checks++; if (best_mid !== 14'd500) begin failures++; $display("FAIL mid_first_load got=%0d exp=500", best_mid); end
        checks++; if (best_sad !== 14'd100) begin failures++; $display("FAIL mid_best_sad got=%0d exp=100", best_sad); end
        checks++; if (best_idx !== 3'd4) begin failures++; $display("FAIL mid_best_idx got=%0d exp=4", best_idx); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_done got=%0b exp=1", busy); end
    endtask

    task automatic test_hold_ack();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b1 || best_sad !== 14'd100 || best_idx !== 3'd4) begin
                failures++;
                $display("FAIL hold_ack cyc=%0d got done=%0b sad=%0d idx=%0d exp 1/100/4", i, done, best_sad, best_idx);
            end
        end
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL ack_release got done=%0b busy=%0b exp 0/0", done, busy); end
    endtask

    task automatic test_ties();
        load_tab(1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000);
        run_search(1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL tie_timeout got=no_done exp=done"); end
        checks++; if (best_sad !== 14'd1000) begin failures++; $display("FAIL tie_best_sad got=%0d exp=1000", best_sad); end
        checks++; if (best_idx !== 3'd0) begin failures++; $display("FAIL tie_best_idx got=%0d exp=0", best_idx); end
        finish_ack();
    endtask

    task automatic test_min_last();
        load_tab(16320, 16320, 16320, 16320, 16320, 16320, 16320, 0);
        run_search(1'b0);
        checks++; if (best_mid !== 14'd16320) begin failures++; $display("FAIL max_first_load got=%0d exp=16320", best_mid); end
        checks++; if (best_sad !== 14'd0) begin failures++; $display("FAIL last_best_sad got=%0d exp=0", best_sad); end
        checks++; if (best_idx !== 3'd7) begin failures++; $display("FAIL last_best_idx got=%0d exp=7", best_idx); end
        finish_ack();
    endtask

    task automatic test_addr_trace();
        load_tab(500, 400, 300, 200, 100, 600, 700, 800);
        run_search(1'b0);
        checks++; if (rd2_cnt != 16) begin failures++; $display("FAIL trace_rd_count got=%0d exp=16", rd2_cnt); end
        checks++; if (!addr2_ok) begin failures++; $display("FAIL trace_can_addr got=out_of_sequence exp=0x20..0x2f"); end
        checks++; if (en2_cnt != 16) begin failures++; $display("FAIL trace_en_count got=%0d exp=16", en2_cnt); end
        checks++; if (!lag_ok) begin failures++; $display("FAIL trace_en_lag got=misaligned exp=mem_rd_delayed_1"); end
        checks++; if (clr2_cnt != 1 || !clr_order_ok) begin
            failures++; $display("FAIL trace_clr got=%0d pulses order_ok=%0b exp=1/1", clr2_cnt, clr_order_ok); end
        finish_ack();
    endtask

    task automatic test_idle_start_abort();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || sad_clr !== 1'b0) begin
            failures++; $display("FAIL start_abort_idle got busy=%0b clr=%0b exp 0/0", busy, sad_clr); end
    endtask

    task automatic test_reset_mid();
        int guard;
        load_tab(500, 400, 300, 200, 100, 600, 700, 800);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (!(mem_rd === 1'b1 && can_addr[6:4] == 3'd3) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checks++; if (guard >= 200) begin failures++; $display("FAIL rstmid_reach got=timeout exp=cand3_read"); end
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || mem_rd !== 1'b0 || sad_en !== 1'b0 || sad_clr !== 1'b0) begin
            failures++; $display("FAIL rstmid_ctrl got busy=%0b done=%0b rd=%0b en=%0b clr=%0b exp all 0",
                                 busy, done, mem_rd, sad_en, sad_clr); end
        checks++; if (ori_addr !== 4'd0 || can_addr !== 7'd0 || best_sad !== 14'd0 || best_idx !== 3'd0) begin
            failures++; $display("FAIL rstmid_data got ori=%0h can=%0h sad=%0d idx=%0d exp all 0",
                                 ori_addr, can_addr, best_sad, best_idx); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_abort();
        int guard;
        int done_seen;
        load_tab(900, 300, 700, 250, 800, 50, 60, 70);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (!(mem_rd === 1'b1 && can_addr[6:4] == 3'd5) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checks++; if (guard >= 200) begin failures++; $display("FAIL abort_reach got=timeout exp=cand5_read"); end
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        ack   = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        ack   = 1'b0;
        checks++; if (busy !== 1'b0 || mem_rd !== 1'b0 || sad_en !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL abort_idle got busy=%0b rd=%0b en=%0b done=%0b exp all 0",
                                 busy, mem_rd, sad_en, done); end
        done_seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        checks++; if (done_seen != 0) begin failures++; $display("FAIL abort_no_done got=%0d active cycles exp=0", done_seen); end
        checks++; if (best_sad !== 14'd250 || best_idx !== 3'd3) begin
            failures++; $display("FAIL abort_best got sad=%0d idx=%0d exp 250/3", best_sad, best_idx); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_min_mid();
        test_hold_ack();
        test_ties();
        test_min_last();
        test_addr_trace();
        test_idle_start_abort();
        test_reset_mid();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
